// File: rtl/median_window_pkg.sv
// Shared types and defaults for the 3x3 window generator feeding the median block.
package median_window_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef logic [DEF_PIX_W-1:0] pix_t;
    typedef pix_t [2:0][2:0]      window_t;

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/median_window_line_buffer.sv
// One line of pixel storage: a single address shared by the read and the write,
// read-before-write, so the old contents of a column are seen in the same cycle
// they are overwritten.
module median_window_line_buffer #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Storage is deliberately not reset; the top never exposes a column before it is written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window.sv
// Streaming 3x3 window generator: raster pixels in, one fully covered interior
// neighbourhood out per accepted pixel, with its centre coordinates.
module median_window
    import median_window_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] arr_0_0,
    output logic [PIX_W-1:0] arr_0_1,
    output logic [PIX_W-1:0] arr_0_2,
    output logic [PIX_W-1:0] arr_1_0,
    output logic [PIX_W-1:0] arr_1_1,
    output logic [PIX_W-1:0] arr_1_2,
    output logic [PIX_W-1:0] arr_2_0,
    output logic [PIX_W-1:0] arr_2_1,
    output logic [PIX_W-1:0] arr_2_2,
    output logic [15:0]      out_x,
    output logic [15:0]      out_y,
    output logic             out_eof
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FULL = CW'(2);
    localparam logic [RW-1:0] ROW_FULL = RW'(2);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          in_fire;
    logic          emit;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
    logic [2:0][2:0][PIX_W-1:0] arr_q, arr_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_x_q, out_x_d;
    logic [15:0]   out_y_q, out_y_d;
    logic          out_eof_q, out_eof_d;

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign cur_col  = in_sof ? '0 : col_q;
    assign cur_row  = in_sof ? '0 : row_q;
    assign emit     = in_fire && (cur_row >= ROW_FULL) && (cur_col >= COL_FULL);

    median_window_line_buffer #(.DEPTH(IMG_W), .AW(CW), .DW(PIX_W)) u_lb0 (
        .clock   (clock),
        .wr_en   (in_fire),
        .addr    (cur_col),
        .wr_data (in_pix),
        .rd_data (lb0_rd)
    );

    median_window_line_buffer #(.DEPTH(IMG_W), .AW(CW), .DW(PIX_W)) u_lb1 (
        .clock   (clock),
        .wr_en   (in_fire),
        .addr    (cur_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Raster position of the next pixel; in_sof forces the current pixel to (0,0).
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_fire) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Shift the window one column left and insert the column {two lines ago, last line, new pixel}.
    always_comb begin
        win_d = win_q;
        if (in_fire) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = in_pix;
        end
    end

    // Output register: reload on emission, otherwise hold until the window is taken.
    always_comb begin
        arr_d       = arr_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_eof_d   = out_eof_q;
        out_valid_d = out_valid_q && !out_ready;
        if (emit) begin
            arr_d       = win_d;
            out_x_d     = 16'(cur_col) - 16'd1;
            out_y_d     = 16'(cur_row) - 16'd1;
            out_eof_d   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            out_valid_d = 1'b1;
        end
    end

    // State registers; an asserted reset drops any held window and restarts at (0,0).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            arr_q       <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            arr_q       <= arr_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_eof   = out_eof_q;
    assign arr_0_0   = arr_q[0][0];
    assign arr_0_1   = arr_q[0][1];
    assign arr_0_2   = arr_q[0][2];
    assign arr_1_0   = arr_q[1][0];
    assign arr_1_1   = arr_q[1][1];
    assign arr_1_2   = arr_q[1][2];
    assign arr_2_0   = arr_q[2][0];
    assign arr_2_1   = arr_q[2][1];
    assign arr_2_2   = arr_q[2][2];

endmodule

// File: tb/tb_median_window.sv
// Directed bench for median_window on a 5x4 image with pixel value row*16+col.
module tb_median_window;

    localparam int W = 5;
    localparam int H = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [7:0]  in_pix;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  arr_0_0, arr_0_1, arr_0_2;
    logic [7:0]  arr_1_0, arr_1_1, arr_1_2;
    logic [7:0]  arr_2_0, arr_2_1, arr_2_2;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        out_eof;

    typedef struct packed {
        logic [15:0]     x;
        logic [15:0]     y;
        logic            eof;
        logic [8:0][7:0] taps;
        logic [7:0]      med;
    } win_exp_t;

    win_exp_t sb[$];

    int   errors = 0;
    int   checks = 0;
    int   tb_row = 0;
    int   tb_col = 0;
    logic model_ov = 1'b0;
    int   win_count = 0;
    int   eof_count = 0;

    logic [8:0][7:0] first_taps, last_taps;
    logic [15:0]     first_x, first_y, last_x, last_y;
    logic            last_eof;

    median_window #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .arr_0_0   (arr_0_0),
        .arr_0_1   (arr_0_1),
        .arr_0_2   (arr_0_2),
        .arr_1_0   (arr_1_0),
        .arr_1_1   (arr_1_1),
        .arr_1_2   (arr_1_2),
        .arr_2_0   (arr_2_0),
        .arr_2_1   (arr_2_1),
        .arr_2_2   (arr_2_2),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_eof   (out_eof)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] pix_at(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    function automatic logic [7:0] median9(input logic [8:0][7:0] t);
        logic [7:0] a [9];
        logic [7:0] tmp;
        for (int i = 0; i < 9; i++) a[i] = t[i];
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    tmp    = a[j];
                    a[j]   = a[j+1];
                    a[j+1] = tmp;
                end
            end
        end
        return a[4];
    endfunction

    task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0][7:0] observed_taps();
        logic [8:0][7:0] o;
        o[0] = arr_0_0; o[1] = arr_0_1; o[2] = arr_0_2;
        o[3] = arr_1_0; o[4] = arr_1_1; o[5] = arr_1_2;
        o[6] = arr_2_0; o[7] = arr_2_1; o[8] = arr_2_2;
        return o;
    endfunction

    // One clock cycle: drive inputs, check at the falling edge, update the model.
    task automatic apply_stimulus(input logic v, input logic sof, input logic ordy);
        int              prow, pcol;
        logic            fire, next_ov;
        win_exp_t        e;
        logic [8:0][7:0] o;
        prow      = sof ? 0 : tb_row;
        pcol      = sof ? 0 : tb_col;
        in_valid  = v;
        in_sof    = sof;
        in_pix    = pix_at(prow, pcol);
        out_ready = ordy;
        #4;
        check_output("in_ready", 72'(in_ready), 72'(!model_ov || ordy));
        check_output("out_valid", 72'(out_valid), 72'(model_ov));
        if (model_ov) begin
            if (sb.size() == 0) begin
                check_output("sb_underflow", 72'(sb.size()), 72'(1));
            end else begin
                e = sb[0];
                o = observed_taps();
                check_output("out_x", 72'(out_x), 72'(e.x));
                check_output("out_y", 72'(out_y), 72'(e.y));
                check_output("out_eof", 72'(out_eof), 72'(e.eof));
                check_output("taps", 72'(o), 72'(e.taps));
                check_output("median", 72'(median9(o)), 72'(e.med));
                if (ordy) begin
                    void'(sb.pop_front());
                    if (win_count == 0) begin
                        first_taps = o;
                        first_x    = out_x;
                        first_y    = out_y;
                    end
                    last_taps = o;
                    last_x    = out_x;
                    last_y    = out_y;
                    last_eof  = out_eof;
                    win_count++;
                    if (out_eof) eof_count++;
                end
            end
        end
        fire    = v && (!model_ov || ordy);
        next_ov = model_ov && !ordy;
        if (fire) begin
            if (prow >= 2 && pcol >= 2) begin
                e.x   = 16'(pcol - 1);
                e.y   = 16'(prow - 1);
                e.eof = (prow == H - 1) && (pcol == W - 1);
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.taps[r*3+c] = pix_at(prow - 2 + r, pcol - 2 + c);
                e.med = pix_at(prow - 1, pcol - 1);
                sb.push_back(e);
                next_ov = 1'b1;
            end
            if (pcol == W - 1) begin
                tb_col = 0;
                tb_row = (prow == H - 1) ? 0 : prow + 1;
            end else begin
                tb_col = pcol + 1;
                tb_row = prow;
            end
        end
        model_ov = next_ov;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("sb_drained", 72'(sb.size()), 72'(0));
    endtask

    task automatic clear_counts();
        win_count = 0;
        eof_count = 0;
    endtask

    task automatic check_first_last();
        check_output("first_arr_0_0", 72'(first_taps[0]), 72'(8'h00));
        check_output("first_arr_0_2", 72'(first_taps[2]), 72'(8'h02));
        check_output("first_arr_2_0", 72'(first_taps[6]), 72'(8'h20));
        check_output("first_arr_2_2", 72'(first_taps[8]), 72'(8'h22));
        check_output("first_x", 72'(first_x), 72'(16'd1));
        check_output("first_y", 72'(first_y), 72'(16'd1));
        check_output("first_med", 72'(median9(first_taps)), 72'(8'h11));
        check_output("last_x", 72'(last_x), 72'(16'd3));
        check_output("last_y", 72'(last_y), 72'(16'd2));
        check_output("last_eof", 72'(last_eof), 72'(1'b1));
        check_output("last_med", 72'(median9(last_taps)), 72'(8'h23));
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pix    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        // Reset state
        check_output("rst_out_valid", 72'(out_valid), 72'(0));
        check_output("rst_in_ready", 72'(in_ready), 72'(1));
        check_output("rst_out_eof", 72'(out_eof), 72'(0));
        check_output("rst_out_x", 72'(out_x), 72'(0));
        check_output("rst_out_y", 72'(out_y), 72'(0));
        check_output("rst_taps", 72'(observed_taps()), 72'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Test 1: full frame at full rate
        clear_counts();
        for (int i = 0; i < W * H; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        drain();
        check_output("t1_windows", 72'(win_count), 72'(6));
        check_output("t1_eofs", 72'(eof_count), 72'(1));
        check_first_last();

        // Test 2: backpressure on the first window
        clear_counts();
        for (int i = 0; i < 13; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 13; i < W * H; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        drain();
        check_output("t2_windows", 72'(win_count), 72'(6));

        // Test 3: in_valid toggling every cycle
        clear_counts();
        for (int i = 0; i < 2 * W * H; i++) apply_stimulus((i % 2) == 0, 1'b0, 1'b1);
        drain();
        check_output("t3_windows", 72'(win_count), 72'(6));
        check_first_last();

        // Test 4: in_sof at counter position (1,3) restarts the frame
        clear_counts();
        for (int i = 0; i < W + 3; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < W * H; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        drain();
        check_output("t4_windows", 72'(win_count), 72'(6));
        check_output("t4_eofs", 72'(eof_count), 72'(1));

        // Test 5: reset mid-frame after pixel (2,3)
        for (int i = 0; i < 2 * W + 4; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check_output("t5_async_out_valid", 72'(out_valid), 72'(0));
        check_output("t5_async_in_ready", 72'(in_ready), 72'(1));
        sb.delete();
        model_ov = 1'b0;
        tb_row   = 0;
        tb_col   = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        clear_counts();
        for (int i = 0; i < W * H; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        drain();
        check_output("t5_windows", 72'(win_count), 72'(6));
        check_first_last();

        // Test 6: two frames back to back without in_sof
        clear_counts();
        for (int i = 0; i < 2 * W * H; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
        drain();
        check_output("t6_windows", 72'(win_count), 72'(12));
        check_output("t6_eofs", 72'(eof_count), 72'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
